// File: rtl/frame_bank_server.sv
// frame_bank_server
// Memory-side responder for the 64x64 RGB filter pipeline. Two ping-pong
// image banks: a frame is loaded from the input stream, the processing
// engine reads the read bank and writes the other bank, the banks swap at
// every stage boundary, and the final frame is streamed out.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_valid/s_ready/s_pix         input pixel stream, raster order
//   row, col, in_pix              engine read port (combinational)
//   out_we, out_pix               engine write port, same address as read
//   mirror_done/gray_done/
//   filter_done                   stage-boundary pulses
//   m_valid/m_ready/m_pix/m_last  output pixel stream, raster order
//   busy                          engine is being served
module frame_bank_server #(
  parameter int W      = 24,
  parameter int N_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W-1:0]      s_pix,
  input  logic [N_LOG2-1:0] row,
  input  logic [N_LOG2-1:0] col,
  output logic [W-1:0]      in_pix,
  input  logic              out_we,
  input  logic [W-1:0]      out_pix,
  input  logic              mirror_done,
  input  logic              gray_done,
  input  logic              filter_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W-1:0]      m_pix,
  output logic              m_last,
  output logic              busy
);

  localparam int AW    = 2 * N_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] K_LAST   = '1;
  localparam logic [AW-1:0] K_PENULT = AW'(DEPTH - 2);

  typedef enum logic [1:0] {LOAD, SERVE, DUMP} state_t;

  state_t        state_q;
  logic [AW-1:0] k_q;
  logic          rd_bank_q;
  logic          s_ready_q, busy_q, m_valid_q, m_last_q;

  logic [W-1:0]  bank_a [DEPTH];
  logic [W-1:0]  bank_b [DEPTH];

  logic          s_acc, m_acc;
  logic          wr_en, wr_sel_b;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data, rd_data;

  // The flag registers are only ever set in their own state, so they double
  // as state decodes for the handshakes.
  assign s_acc = s_ready_q & s_valid;
  assign m_acc = m_valid_q & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      k_q       <= '0;
      rd_bank_q <= 1'b0;
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (s_acc) begin
            if (k_q == K_LAST) begin
              k_q       <= '0;
              state_q   <= SERVE;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        SERVE: begin
          // Simultaneous done pulses toggle once; filter_done also ends serving.
          if (filter_done) begin
            rd_bank_q <= ~rd_bank_q;
            state_q   <= DUMP;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
          end else if (mirror_done | gray_done) begin
            rd_bank_q <= ~rd_bank_q;
          end
        end
        DUMP: begin
          if (m_acc) begin
            if (k_q == K_LAST) begin
              k_q       <= '0;
              state_q   <= LOAD;
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              s_ready_q <= 1'b1;
            end else begin
              k_q      <= k_q + 1'b1;
              m_last_q <= (k_q == K_PENULT);
            end
          end
        end
        default: begin
          state_q   <= LOAD;
          k_q       <= '0;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Single write port: the load stream fills the read bank, the engine
  // writes the opposite bank. Reset blocks writes so memory is untouched.
  always_comb begin
    wr_en    = 1'b0;
    wr_sel_b = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    if (!rst) begin
      if (s_acc) begin
        wr_en    = 1'b1;
        wr_sel_b = rd_bank_q;
        wr_addr  = k_q;
        wr_data  = s_pix;
      end else if (busy_q && out_we) begin
        wr_en    = 1'b1;
        wr_sel_b = ~rd_bank_q;
        wr_addr  = {row, col};
        wr_data  = out_pix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel_b) bank_b[wr_addr] <= wr_data;
      else          bank_a[wr_addr] <= wr_data;
    end
  end

  // Shared read port: engine address while serving, raster index otherwise.
  assign rd_addr = busy_q ? {row, col} : k_q;
  assign rd_data = rd_bank_q ? bank_b[rd_addr] : bank_a[rd_addr];

  assign in_pix  = busy_q    ? rd_data : '0;
  assign m_pix   = m_valid_q ? rd_data : '0;
  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_frame_bank_server.sv
module tb_frame_bank_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_pix;
  logic [5:0]  row, col;
  logic [23:0] in_pix;
  logic        out_we;
  logic [23:0] out_pix;
  logic        mirror_done, gray_done, filter_done;
  logic        m_valid, m_ready;
  logic [23:0] m_pix;
  logic        m_last;
  logic        busy;

  always #5 clk = ~clk;

  frame_bank_server #(.W(24), .N_LOG2(6)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix),
    .row(row), .col(col), .in_pix(in_pix),
    .out_we(out_we), .out_pix(out_pix),
    .mirror_done(mirror_done), .gray_done(gray_done), .filter_done(filter_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_pix(m_pix), .m_last(m_last),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [23:0] pix;
    logic        last;
  } beat_t;

  beat_t       sq[$];   // expected output-stream beats
  logic [23:0] rdq[$];  // expected engine read values
  logic        rd_chk = 1'b0;
  int          dump_cnt = 0;

  // Reference model: two images and which one is being read.
  logic [23:0] mem0 [4096];
  logic [23:0] mem1 [4096];
  logic        rdsel;

  function automatic logic [23:0] mdl_rd(input logic [11:0] a);
    return rdsel ? mem1[a] : mem0[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compares whenever the DUT presents data.
  always @(negedge clk) begin : monitor
    logic [23:0] e;
    beat_t b;
    if (rd_chk) begin
      if (rdq.size() == 0) fail_now("rd_queue_underflow");
      else begin
        e = rdq.pop_front();
        chk("in_pix", {8'h0, in_pix}, {8'h0, e});
      end
    end
    if (m_valid) begin
      if (sq.size() == 0) fail_now("stream_extra_beat");
      else begin
        b = sq[0];
        chk("m_pix", {8'h0, m_pix}, {8'h0, b.pix});
        chk("m_last", {31'h0, m_last}, {31'h0, b.last});
        if (m_ready) begin
          void'(sq.pop_front());
          dump_cnt++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_op(input logic [5:0] r, input logic [5:0] c,
                          input logic we, input logic [23:0] d,
                          input logic md, input logic gd, input logic fd);
    row = r; col = c; out_we = we; out_pix = d;
    mirror_done = md; gray_done = gd; filter_done = fd;
    if (we) begin
      if (rdsel) mem0[{r, c}] = d;
      else       mem1[{r, c}] = d;
    end
    if (md | gd | fd) rdsel = ~rdsel;
    cyc();
    out_we = 1'b0; mirror_done = 1'b0; gray_done = 1'b0; filter_done = 1'b0;
  endtask

  task automatic read_exp(input logic [5:0] r, input logic [5:0] c, input logic [23:0] exp);
    row = r; col = c;
    rdq.push_back(exp);
    rd_chk = 1'b1;
    cyc();
    rd_chk = 1'b0;
  endtask

  task automatic eng_read(input logic [5:0] r, input logic [5:0] c, output logic [23:0] v);
    row = r; col = c;
    rdq.push_back(mdl_rd({r, c}));
    rd_chk = 1'b1;
    @(negedge clk);
    v = in_pix;
    cyc();
    rd_chk = 1'b0;
  endtask

  initial begin : driver
    logic [23:0] v;
    int src, cnt;
    beat_t b;

    rst = 1'b1; s_valid = 1'b0; s_pix = '0; row = '0; col = '0;
    out_we = 1'b0; out_pix = '0; mirror_done = 1'b0; gray_done = 1'b0;
    filter_done = 1'b0; m_ready = 1'b0; rdsel = 1'b0;
    cyc(); cyc();
    chk("rst_s_ready", {31'h0, s_ready}, 32'd1);
    chk("rst_busy",    {31'h0, busy},    32'd0);
    chk("rst_m_valid", {31'h0, m_valid}, 32'd0);
    chk("rst_m_last",  {31'h0, m_last},  32'd0);
    chk("rst_in_pix",  {8'h0, in_pix},   32'd0);
    rst = 1'b0;

    // Partial random frame aborted by reset at k=2000.
    s_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      s_pix = 24'($urandom);
      mem0[i] = s_pix;
      cyc();
    end
    s_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; rdsel = 1'b0;
    chk("abort_s_ready", {31'h0, s_ready}, 32'd1);
    chk("abort_busy",    {31'h0, busy},    32'd0);

    // Continuous ramp load; stray done pulses and a write are ignored.
    s_valid = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      s_pix       = 24'(i);
      filter_done = (i == 100);
      mirror_done = (i == 200);
      out_we      = (i == 300);
      out_pix     = 24'hFFFFFF;
      mem0[i]     = 24'(i);
      cyc();
      if (i == 100) chk("load_filter_ignored", {31'h0, m_valid}, 32'd0);
      if (i == 4094) chk("busy_before_last", {31'h0, busy}, 32'd0);
      if (i == 4095) begin
        chk("busy_after_4096", {31'h0, busy}, 32'd1);
        chk("s_ready_serve",   {31'h0, s_ready}, 32'd0);
      end
    end
    s_valid = 1'b0; filter_done = 1'b0; mirror_done = 1'b0; out_we = 1'b0;

    // Swap behaviour.
    read_exp(6'd5, 6'd7, 24'h000147);
    serve_op(6'd0, 6'd0, 1'b1, 24'hAABBCC, 1'b0, 1'b0, 1'b0);
    serve_op(6'd0, 6'd0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    read_exp(6'd0, 6'd0, 24'hAABBCC);
    serve_op(6'd0, 6'd0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    read_exp(6'd0, 6'd0, 24'h000000);
    serve_op(6'd3, 6'd3, 1'b1, 24'h123456, 1'b1, 1'b0, 1'b0);
    read_exp(6'd3, 6'd3, 24'h123456);
    serve_op(6'd0, 6'd0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    serve_op(6'd0, 6'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);  // two pulses, one toggle
    read_exp(6'd0, 6'd0, 24'hAABBCC);
    serve_op(6'd0, 6'd0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      src = int'($urandom_range(0, 4095));
      read_exp(6'(src >> 6), 6'(src & 63), 24'(src));
    end

    // Behavioural engine: mirror each row, keep green only, identity filter.
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        eng_read(6'(r), 6'(63 - c), v);
        serve_op(6'(r), 6'(c), 1'b1, v, 1'b0, 1'b0, 1'b0);
      end
    serve_op(6'd0, 6'd0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        eng_read(6'(r), 6'(c), v);
        serve_op(6'(r), 6'(c), 1'b1, {8'h0, v[15:8], 8'h0}, 1'b0, 1'b0, 1'b0);
      end
    serve_op(6'd0, 6'd0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        eng_read(6'(r), 6'(c), v);
        serve_op(6'(r), 6'(c), 1'b1, v, 1'b0, 1'b0, 1'b0);
      end

    // Final frame is the row-mirrored ramp reduced to its green byte.
    for (int k = 0; k < 4096; k++) begin
      src    = (k / 64) * 64 + (63 - (k % 64));
      b.pix  = {8'h0, 8'(src >> 8), 8'h0};
      b.last = (k == 4095);
      sq.push_back(b);
    end
    m_ready = 1'b0;
    serve_op(6'd0, 6'd0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    chk("dump_m_valid", {31'h0, m_valid}, 32'd1);
    chk("dump_busy",    {31'h0, busy},    32'd0);

    // Dump with m_ready toggling every 3 cycles.
    rdq.push_back(24'h0);
    rd_chk = 1'b1;
    cnt = 0;
    while (dump_cnt < 4096 && cnt < 20000) begin
      if (cnt % 3 == 0) m_ready = ~m_ready;
      cyc();
      rd_chk = 1'b0;
      cnt++;
    end
    m_ready = 1'b0;
    if (cnt >= 20000) fail_now("dump_timeout");
    chk("post_dump_s_ready", {31'h0, s_ready}, 32'd1);
    chk("post_dump_m_valid", {31'h0, m_valid}, 32'd0);
    chk("beats_left", 32'(sq.size()), 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_bank_server.md
# frame_bank_server

Memory-side responder for the 64x64 RGB image filter pipeline. Accepts an input frame over a pixel stream and serves the processing engine's `row`/`col` read and `out_we` write interface from two ping-pong image banks. It swaps banks at each stage boundary (`mirror_done`, `gray_done`), so each stage reads the previous stage's output. After `filter_done` it streams the final frame out. It sits between the frame source/sink and the processing engine.

## Interface
- `W`, 24: pixel width, R 23:16, G 15:8, B 7:0.
- `N_LOG2`, 6: log2 of image side; the frame is 64x64 = 4096 pixels.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input stream pixel valid.
- `s_ready` out 1: block accepts an input pixel.
- `s_pix` in 24: input stream pixel, raster order.
- `row` in 6: engine row address.
- `col` in 6: engine column address.
- `in_pix` out 24: pixel at [`row`,`col`] of the read bank.
- `out_we` in 1: engine write enable.
- `out_pix` in 24: engine write data for [`row`,`col`].
- `mirror_done` in 1: end of mirror stage.
- `gray_done` in 1: end of grayscale stage.
- `filter_done` in 1: end of sharpen stage.
- `m_valid` out 1: output stream pixel valid.
- `m_ready` in 1: downstream accepts the output pixel.
- `m_pix` out 24: output stream pixel, raster order.
- `m_last` out 1: marks pixel 4095 of the output frame.
- `busy` out 1: engine is being served (SERVE state).

## Operation
- Storage:
  - Two banks, A and B, each 4096 x 24.
  - Address = {`row`,`col`} (12 bits); row is the high field.
  - `rd_bank` register selects the read bank; the write bank is always `~rd_bank`.
- Raster index k maps to row = k[11:6], col = k[5:0].
- FSM has 3 states: LOAD, SERVE, DUMP.
- LOAD:
  - `s_ready`=1.
  - Each `s_valid&s_ready` writes `s_pix` to `rd_bank`[k] and increments k.
  - On k=4095 accepted, go to SERVE and clear k.
- SERVE:
  - `busy`=1.
  - `in_pix` = `rd_bank`[{`row`,`col`}], combinational, same cycle.
  - `out_we`=1 writes `out_pix` into write bank at {`row`,`col`} on the clock edge.
  - `mirror_done` or `gray_done` toggles `rd_bank`.
  - `filter_done` toggles `rd_bank` and goes to DUMP.
- DUMP:
  - `m_valid`=1; `m_pix` = `rd_bank`[k], combinational; `m_last` = (k==4095).
  - `m_valid&m_ready` increments k.
  - On k=4095 accepted, clear k and go to LOAD. The next frame overwrites the current `rd_bank`.
- Bank sequence from reset: load A; mirror A->B; gray B->A; filter A->B; dump B.
- Locations the engine does not write keep stale contents; banks are never cleared.

## Timing
- Reset values:
  - State LOAD, k=0, `rd_bank`=0.
  - `s_ready`=1, `m_valid`=0, `m_last`=0, `busy`=0.
- Memory contents are unaffected by reset.
- Reset mid-frame (any state) aborts the frame: LOAD, k=0, `rd_bank`=0 on the next cycle.
- `in_pix` is 0 outside SERVE.
- In SERVE, `in_pix` reflects a write issued in an earlier cycle only if it targets the read bank, which by construction it never does.
- Write coinciding with a done pulse: `out_we`=1 in the same cycle as a done pulse writes the pre-toggle write bank.
- Done pulses outside SERVE are ignored.
- `out_we` outside SERVE is ignored; no bank is written.
- More than one done pulse in the same SERVE cycle: toggle once. `filter_done` takes priority and moves the FSM to DUMP.
- `s_valid` outside LOAD is ignored; `s_ready`=0.
- `m_ready` low holds `m_pix`, `m_last` and k stable.
- Output stream: `m_valid`, `m_pix` and `m_last` hold until accepted.
- Latency:
  - Last input accepted -> `busy`=1 next cycle.
  - `filter_done` -> `m_valid`=1 next cycle.
  - Last output accepted -> `s_ready`=1 next cycle.
- Stream throughput: 1 pixel/cycle on each stream when the partner holds valid/ready high.

## Test plan
- Load ramp `s_pix`=k continuously, then read (r=5,c=7) in SERVE -> `in_pix`=0x000147; `busy` rises exactly 4096 cycles after first accept.
- Mirror/gray swap:
  - Write 0xAABBCC at (0,0) in SERVE, then pulse `mirror_done` -> read (0,0) returns 0xAABBCC.
  - Pulse `gray_done` -> (0,0) returns the ramp value 0.
- Full pipeline with a behavioural engine (mirror, gray, identity filter) on ramp input -> dump emits 4096 pixels, each `{8'h0,G,8'h0}` of the row-mirrored ramp, with `m_last` only on the 4096th.
- Backpressure: toggle `m_ready` every 3 cycles during DUMP -> no pixel lost or duplicated; `m_pix` stable while stalled.
- Write with done pulse: `out_we`=1 with `out_pix`=0x123456 at (3,3) in the same cycle as `mirror_done` -> after the swap, (3,3) reads 0x123456.
- Reset at k=2000 of LOAD, then reload -> `rd_bank`=0 and SERVE entry after exactly 4096 fresh accepts. Also: `filter_done` pulsed in LOAD is ignored.
